// File: rtl/mdio_master_param.sv
// mdio_master_param
//   MDIO management master (Clause 22, optionally Clause 45).
//   Serialises one 32-bit frame per accepted request.
//   The frame is an optional all-ones preamble, then 14 header bits, 2 turnaround bits and 16 data bits.
//   MDC is a divided copy of i_clk. It is built from a counter and toggles only while a frame is in progress.
//   Read data is shifted in on each MDC rise during the data field.
//   The captured word is published with a one-cycle valid pulse when the frame ends.
//
// Configuration macro: MDIO_C45_EN
//   When defined, ST=00 frames are also accepted as Clause 45.
//   OP=1x is a read; OP=0x is an address or write.
//
// Parameters
//   DIV      MDC half-period in i_clk cycles (>=1)
//   PRE_LEN  number of preamble '1' bits (0..32)
//
// Ports
//   i_clk          system clock, all state updates on its rising edge
//   i_reset        synchronous, active-low reset
//   i_start_stb    request pulse, taken only while o_busy=0
//   i_transaccion  {ST,OP,PHYAD,REGAD,TA,DATA} frame image
//   o_busy         frame in progress
//   o_err_stb      one-cycle pulse, request rejected (illegal ST/OP)
//   o_rd_data      last captured read data
//   o_rd_data_vld  one-cycle pulse, o_rd_data updated
//   o_mdc          management clock, low when idle
//   o_mdio_out     serial data towards the pad
//   o_mdio_oe      pad output enable (1 = master drives)
//   i_mdio_in      serial data from the pad
module mdio_master_param #(
  parameter int DIV     = 2,
  parameter int PRE_LEN = 32
) (
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic        i_start_stb,
  input  logic [31:0] i_transaccion,
  output logic        o_busy,
  output logic        o_err_stb,
  output logic [15:0] o_rd_data,
  output logic        o_rd_data_vld,
  output logic        o_mdc,
  output logic        o_mdio_out,
  output logic        o_mdio_oe,
  input  logic        i_mdio_in
);

  localparam int            CW       = $clog2(2 * DIV) + 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(2 * DIV - 1);
  localparam logic [CW-1:0] CNT_RISE = CW'(DIV - 1);
  localparam logic [5:0]    PRE_LAST = 6'((PRE_LEN > 0) ? (PRE_LEN - 1) : 0);

  typedef enum logic [2:0] {S_IDLE, S_PRE, S_HDR, S_TA, S_DAT} state_t;

  state_t        r_state;
  logic [CW-1:0] r_cnt;    // position inside the current bit period
  logic [5:0]    r_bits;   // bits remaining in the current field, minus one
  logic [31:0]   r_sh;     // frame image; bit 31 is the next bit to send
  logic          r_read;
  logic [15:0]   r_rd_sh;

  logic [1:0] w_st;
  logic [1:0] w_op;
  logic       w_legal;
  logic       w_read;
  logic       w_bit_end;
  logic       w_rise;

  assign w_st = i_transaccion[31:30];
  assign w_op = i_transaccion[29:28];

`ifdef MDIO_C45_EN
  assign w_legal = ((w_st == 2'b01) && ((w_op == 2'b01) || (w_op == 2'b10))) || (w_st == 2'b00);
  assign w_read  = ((w_st == 2'b01) && (w_op == 2'b10)) || ((w_st == 2'b00) && w_op[1]);
`else
  assign w_legal = (w_st == 2'b01) && ((w_op == 2'b01) || (w_op == 2'b10));
  assign w_read  = (w_op == 2'b10);
`endif

  assign w_bit_end = (r_cnt == CNT_LAST);
  assign w_rise    = (r_cnt == CNT_RISE);

  // Frame sequencer: bit timing, serialisation, read capture and handshake outputs.
  // During turnaround and data, the driven value is masked to 0 on reads because the pad is released.
  always_ff @(posedge i_clk) begin
    if (!i_reset) begin
      r_state       <= S_IDLE;
      r_cnt         <= '0;
      r_bits        <= 6'd0;
      r_sh          <= 32'd0;
      r_read        <= 1'b0;
      r_rd_sh       <= 16'd0;
      o_busy        <= 1'b0;
      o_err_stb     <= 1'b0;
      o_rd_data     <= 16'd0;
      o_rd_data_vld <= 1'b0;
      o_mdc         <= 1'b0;
      o_mdio_out    <= 1'b0;
      o_mdio_oe     <= 1'b0;
    end else begin
      o_err_stb     <= 1'b0;
      o_rd_data_vld <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (i_start_stb) begin
            if (w_legal) begin
              o_busy    <= 1'b1;
              o_mdc     <= 1'b0;
              o_mdio_oe <= 1'b1;
              r_cnt     <= '0;
              r_read    <= w_read;
              if (PRE_LEN > 0) begin
                r_state    <= S_PRE;
                r_bits     <= PRE_LAST;
                o_mdio_out <= 1'b1;
                r_sh       <= i_transaccion;
              end else begin
                r_state    <= S_HDR;
                r_bits     <= 6'd13;
                o_mdio_out <= i_transaccion[31];
                r_sh       <= {i_transaccion[30:0], 1'b0};
              end
            end else begin
              o_err_stb <= 1'b1;
            end
          end
        end
        S_PRE, S_HDR, S_TA, S_DAT: begin
          if (w_bit_end) begin
            r_cnt <= '0;
            o_mdc <= 1'b0;
            case (r_state)
              S_PRE: begin
                if (r_bits == 6'd0) begin
                  r_state    <= S_HDR;
                  r_bits     <= 6'd13;
                  o_mdio_out <= r_sh[31];
                  r_sh       <= {r_sh[30:0], 1'b0};
                end else begin
                  r_bits     <= r_bits - 6'd1;
                  o_mdio_out <= 1'b1;
                end
              end
              S_HDR: begin
                r_sh <= {r_sh[30:0], 1'b0};
                if (r_bits == 6'd0) begin
                  // First turnaround bit: writes drive '1', reads release the pad.
                  r_state    <= S_TA;
                  r_bits     <= 6'd1;
                  o_mdio_out <= ~r_read;
                  o_mdio_oe  <= ~r_read;
                end else begin
                  r_bits     <= r_bits - 6'd1;
                  o_mdio_out <= r_sh[31];
                end
              end
              S_TA: begin
                r_sh <= {r_sh[30:0], 1'b0};
                if (r_bits == 6'd0) begin
                  r_state    <= S_DAT;
                  r_bits     <= 6'd15;
                  o_mdio_out <= r_sh[31] & ~r_read;
                end else begin
                  r_bits     <= r_bits - 6'd1;
                  o_mdio_out <= 1'b0;
                end
              end
              S_DAT: begin
                if (r_bits == 6'd0) begin
                  r_state    <= S_IDLE;
                  o_busy     <= 1'b0;
                  o_mdio_out <= 1'b0;
                  o_mdio_oe  <= 1'b0;
                  if (r_read) begin
                    o_rd_data     <= r_rd_sh;
                    o_rd_data_vld <= 1'b1;
                  end
                end else begin
                  r_bits     <= r_bits - 6'd1;
                  o_mdio_out <= r_sh[31] & ~r_read;
                  r_sh       <= {r_sh[30:0], 1'b0};
                end
              end
              default: r_state <= S_IDLE;
            endcase
          end else begin
            r_cnt <= r_cnt + CW'(1);
            if (w_rise) begin
              o_mdc <= 1'b1;
              if (r_state == S_DAT) begin
                r_rd_sh <= {r_rd_sh[14:0], i_mdio_in};
              end
            end
          end
        end
        default: begin
          r_state <= S_IDLE;
          o_busy  <= 1'b0;
          o_mdc   <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mdio_master_param.sv
// Bench for mdio_master_param.
// Two instances are built: one with DIV=2 and PRE_LEN=32, and one with DIV=1 and PRE_LEN=0.
// Each instance has its own stimulus process, PHY responder and frame monitor.
// Stimulus pushes a model-computed frame description into a queue.
// The monitor pops it when o_busy rises and compares the whole frame when o_busy falls.
module tb_mdio_master_param;

  int vectors     = 0;
  int miscompares = 0;
  int done_cnt    = 0;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [63:0] bits;   // expected mdio_out per bit index (0 = first bit)
    logic [63:0] oe;     // expected mdio_oe per bit index
    logic        rd;
    logic [15:0] data;   // expected rd_data after the frame
    logic        abort;  // frame is cut short by reset, not compared
  } exp_t;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
    vectors++;
    if (act !== req) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h required 0x%0h", nm, act, req);
    end
  endtask

  function automatic logic legal(input logic [31:0] t);
`ifdef MDIO_C45_EN
    if (t[31:30] == 2'b00) return 1'b1;
`endif
    return (t[31:30] == 2'b01) && (t[29:28] == 2'b01 || t[29:28] == 2'b10);
  endfunction

  function automatic logic is_read(input logic [31:0] t);
`ifdef MDIO_C45_EN
    if (t[31:30] == 2'b00) return t[29];
`endif
    return t[29:28] == 2'b10;
  endfunction

  // Reference frame: preamble ones, 14 header bits, TA, 16 data bits, MSB first.
  function automatic exp_t model(input logic [31:0] t, input logic [15:0] phy,
                                 input logic [15:0] prev_rd, input int pre);
    exp_t e;
    e.bits  = '0;
    e.oe    = '0;
    e.abort = 1'b0;
    e.rd    = is_read(t);
    e.data  = e.rd ? phy : prev_rd;
    for (int i = 0; i < pre; i++) begin
      e.bits[i] = 1'b1;
      e.oe[i]   = 1'b1;
    end
    for (int i = 0; i < 14; i++) begin
      e.bits[pre + i] = t[31 - i];
      e.oe[pre + i]   = 1'b1;
    end
    if (!e.rd) begin
      e.bits[pre + 14] = 1'b1;
      e.bits[pre + 15] = 1'b0;
      e.oe[pre + 14]   = 1'b1;
      e.oe[pre + 15]   = 1'b1;
      for (int i = 0; i < 16; i++) begin
        e.bits[pre + 16 + i] = t[15 - i];
        e.oe[pre + 16 + i]   = 1'b1;
      end
    end
    return e;
  endfunction

  for (genvar g = 0; g < 2; g++) begin : g_inst
    localparam int DIV   = (g == 0) ? 2 : 1;
    localparam int PRE   = (g == 0) ? 32 : 0;
    localparam int NBITS = PRE + 32;

    logic        reset;
    logic        start_stb;
    logic [31:0] transaccion;
    logic        busy;
    logic        err_stb;
    logic [15:0] rd_data;
    logic        rd_data_vld;
    logic        mdc;
    logic        mdio_out;
    logic        mdio_oe;
    logic        mdio_in;

    logic [15:0] phy_word;
    logic [15:0] last_rd;
    exp_t        sb_q[$];

    mdio_master_param #(.DIV(DIV), .PRE_LEN(PRE)) dut (
      .i_clk         (clk),
      .i_reset       (reset),
      .i_start_stb   (start_stb),
      .i_transaccion (transaccion),
      .o_busy        (busy),
      .o_err_stb     (err_stb),
      .o_rd_data     (rd_data),
      .o_rd_data_vld (rd_data_vld),
      .o_mdc         (mdc),
      .o_mdio_out    (mdio_out),
      .o_mdio_oe     (mdio_oe),
      .i_mdio_in     (mdio_in)
    );

    // Issue one request from posedge+1; returns one cycle later.
    task automatic send(input logic [31:0] t, input logic [15:0] phy, input logic abort);
      exp_t e;
      e = model(t, phy, last_rd, PRE);
      e.abort = abort;
      if (legal(t)) begin
        sb_q.push_back(e);
        if (e.rd && !abort) last_rd = phy;
      end
      phy_word    = phy;
      transaccion = t;
      start_stb   = 1'b1;
      @(posedge clk); #1;
      start_stb = 1'b0;
      if (legal(t)) begin
        chk($sformatf("i%0d start_busy", g), {63'd0, busy}, 64'd1);
        chk($sformatf("i%0d start_noerr", g), {63'd0, err_stb}, 64'd0);
      end else begin
        chk($sformatf("i%0d err_pulse", g), {63'd0, err_stb}, 64'd1);
        chk($sformatf("i%0d err_busy", g), {63'd0, busy}, 64'd0);
        chk($sformatf("i%0d err_mdc", g), {63'd0, mdc}, 64'd0);
        @(posedge clk); #1;
        chk($sformatf("i%0d err_single", g), {63'd0, err_stb}, 64'd0);
        chk($sformatf("i%0d err_busy2", g), {63'd0, busy}, 64'd0);
      end
    endtask

    task automatic wait_idle();
      int n;
      n = 0;
      while (busy && n < 20000) begin
        @(posedge clk); #1;
        n++;
      end
      chk($sformatf("i%0d idle_bound", g), {63'd0, busy}, 64'd0);
    endtask

    // Stimulus
    initial begin
      logic [31:0] t;
      reset       = 1'b0;
      start_stb   = 1'b0;
      transaccion = 32'd0;
      phy_word    = 16'd0;
      last_rd     = 16'd0;
      repeat (3) @(posedge clk);
      #1;
      chk($sformatf("i%0d rst_busy", g), {63'd0, busy}, 64'd0);
      chk($sformatf("i%0d rst_err", g), {63'd0, err_stb}, 64'd0);
      chk($sformatf("i%0d rst_rd_data", g), {48'd0, rd_data}, 64'd0);
      chk($sformatf("i%0d rst_vld", g), {63'd0, rd_data_vld}, 64'd0);
      chk($sformatf("i%0d rst_mdc", g), {63'd0, mdc}, 64'd0);
      chk($sformatf("i%0d rst_out", g), {63'd0, mdio_out}, 64'd0);
      chk($sformatf("i%0d rst_oe", g), {63'd0, mdio_oe}, 64'd0);
      reset = 1'b1;
      @(posedge clk); #1;

      // Write 0x5A3C to PHY 3 reg 5
      send({2'b01, 2'b01, 5'd3, 5'd5, 2'b10, 16'h5A3C}, 16'h0000, 1'b0);
      wait_idle();
      // Read PHY 1 reg 2, PHY returns 0xBEEF
      send({2'b01, 2'b10, 5'd1, 5'd2, 2'b00, 16'h0000}, 16'hBEEF, 1'b0);
      wait_idle();

      // Mid-frame start is ignored; next start in the busy-low cycle has no gap
      send({2'b01, 2'b01, 5'd9, 5'd17, 2'b10, 16'hA5C3}, 16'h0000, 1'b0);
      repeat (20 * DIV) @(posedge clk);
      #1;
      transaccion = {2'b01, 2'b10, 5'd31, 5'd31, 2'b00, 16'hFFFF};
      start_stb   = 1'b1;
      @(posedge clk); #1;
      start_stb = 1'b0;
      chk($sformatf("i%0d ignored_noerr", g), {63'd0, err_stb}, 64'd0);
      chk($sformatf("i%0d ignored_busy", g), {63'd0, busy}, 64'd1);
      wait_idle();
      send({2'b01, 2'b01, 5'd21, 5'd6, 2'b10, 16'h0F1E}, 16'h0000, 1'b0);
      wait_idle();

      // Reset during data bit 7 of a write
      send({2'b01, 2'b01, 5'd5, 5'd10, 2'b10, 16'h1357}, 16'h0000, 1'b1);
      repeat ((PRE + 23) * 2 * DIV + DIV) @(posedge clk);
      #1;
      chk($sformatf("i%0d pre_abort_busy", g), {63'd0, busy}, 64'd1);
      reset = 1'b0;
      @(posedge clk); #1;
      chk($sformatf("i%0d abort_busy", g), {63'd0, busy}, 64'd0);
      chk($sformatf("i%0d abort_mdc", g), {63'd0, mdc}, 64'd0);
      chk($sformatf("i%0d abort_oe", g), {63'd0, mdio_oe}, 64'd0);
      chk($sformatf("i%0d abort_rd_data", g), {48'd0, rd_data}, 64'd0);
      reset   = 1'b1;
      last_rd = 16'd0;
      @(posedge clk); #1;
      send({2'b01, 2'b01, 5'd5, 5'd10, 2'b10, 16'h2468}, 16'h0000, 1'b0);
      wait_idle();

      // Illegal requests
      send({2'b10, 2'b01, 5'd1, 5'd1, 2'b10, 16'h1111}, 16'h0000, 1'b0);
      send({2'b01, 2'b11, 5'd1, 5'd1, 2'b10, 16'h2222}, 16'h0000, 1'b0);
      send({2'b01, 2'b00, 5'd1, 5'd1, 2'b10, 16'h3333}, 16'h0000, 1'b0);
      // Clause 45 read: accepted only when the option is built in
      send({2'b00, 2'b11, 5'd4, 5'd7, 2'b00, 16'h0000}, 16'h1234, 1'b0);
      wait_idle();

      // Random requests over every ST/OP combination
      for (int i = 0; i < 10; i++) begin
        t = $urandom;
        send(t, 16'($urandom), 1'b0);
        wait_idle();
      end

      repeat (3) @(posedge clk);
      #1;
      chk($sformatf("i%0d queue_empty", g), 64'(sb_q.size()), 64'd0);
      done_cnt++;
    end

    // PHY responder: drives read data during the data field, noise elsewhere
    initial begin
      int   pk;
      logic pb;
      logic pm;
      pk      = 0;
      pb      = 1'b0;
      pm      = 1'b0;
      mdio_in = 1'b0;
      forever begin
        @(negedge clk);
        if (busy && !pb) pk = 0;
        else if (busy && pm && !mdc) pk++;
        pb = busy;
        pm = mdc;
        if (busy && pk >= PRE + 16 && pk < PRE + 32) mdio_in = phy_word[15 - (pk - PRE - 16)];
        else mdio_in = 1'($urandom_range(0, 1));
      end
    end

    // Monitor: records each frame bit-by-bit and compares against the queued expectation
    initial begin
      exp_t        cur;
      logic        active;
      logic        have;
      logic        seen;
      logic        stable;
      logic        pm;
      int          k;
      int          cyc;
      logic [63:0] gb;
      logic [63:0] go;
      active = 1'b0;
      have   = 1'b0;
      seen   = 1'b0;
      stable = 1'b1;
      pm     = 1'b0;
      k      = 0;
      cyc    = 0;
      gb     = '0;
      go     = '0;
      cur    = '0;
      forever begin
        @(negedge clk);
        if (!active && busy) begin
          active = 1'b1;
          have   = 1'b0;
          if (sb_q.size() == 0) begin
            miscompares++;
            $display("FAIL i%0d unexpected_frame: got a frame, required none", g);
          end else begin
            cur  = sb_q.pop_front();
            have = 1'b1;
          end
          k = 0; cyc = 0; gb = '0; go = '0; pm = mdc; seen = 1'b0; stable = 1'b1;
        end
        if (active) begin
          if (busy) begin
            cyc++;
            if (pm && !mdc) begin
              k++;
              seen = 1'b0;
            end
            if (k < 64) begin
              if (!seen) begin
                gb[k] = mdio_out;
                go[k] = mdio_oe;
                seen  = 1'b1;
              end else if (gb[k] !== mdio_out || go[k] !== mdio_oe) begin
                stable = 1'b0;
              end
            end
            pm = mdc;
          end else begin
            active = 1'b0;
            if (have && !cur.abort) begin
              chk($sformatf("i%0d busy_len", g), 64'(cyc), 64'(NBITS * 2 * DIV));
              chk($sformatf("i%0d bit_count", g), 64'(k + 1), 64'(NBITS));
              chk($sformatf("i%0d oe_pattern", g), go, cur.oe);
              chk($sformatf("i%0d mdio_bits", g), gb & cur.oe, cur.bits);
              chk($sformatf("i%0d bit_stable", g), {63'd0, stable}, 64'd1);
              chk($sformatf("i%0d end_mdc", g), {63'd0, mdc}, 64'd0);
              chk($sformatf("i%0d rd_vld", g), {63'd0, rd_data_vld}, {63'd0, cur.rd});
              chk($sformatf("i%0d rd_data", g), {48'd0, rd_data}, {48'd0, cur.data});
            end
          end
        end
      end
    end
  end

  // Completion and watchdog
  initial begin
    int n;
    n = 0;
    while (done_cnt < 2 && n < 60000) begin
      @(posedge clk);
      n++;
    end
    if (done_cnt < 2) begin
      miscompares++;
      $display("FAIL watchdog: instances done %0d required 2", done_cnt);
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
